// File: rtl/assert_ctrl_seq.sv
// Multi-channel assertion-control sequencer: applies on/off/kill commands to a
// per-channel enable mask, with a timed kill holdoff and optional auto re-arm.
module assert_ctrl_seq #(
  parameter int NUM_CH     = 4,
  parameter int LEVEL      = 1,
  parameter int HOLD_W     = 4,
  parameter int CNT_W      = 8,
  parameter bit AUTO_REARM = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [NUM_CH-1:0] cmd_mask,
  input  logic [HOLD_W-1:0] cmd_holdoff,
  output logic              cmd_ready,
  output logic [NUM_CH-1:0] ch_enabled,
  output logic              kill_pulse,
  output logic              busy,
  output logic [CNT_W-1:0]  kill_cnt,
  output logic              ctrl_out
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_ON   = 2'b01;
  localparam logic [1:0] OP_OFF  = 2'b10;
  localparam logic [1:0] OP_KILL = 2'b11;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [NUM_CH-1:0]   kill_set_q, kill_set_d;
  logic [NUM_CH-1:0]   ch_en_q, ch_en_d;
  logic                kill_pulse_q, kill_pulse_d;
  logic [CNT_W-1:0]    kill_cnt_q, kill_cnt_d;

  logic                accept;
  logic                effective;
  logic                fire_on;
  logic                fire_off;
  logic                fire_kill;

  assign accept    = cmd_valid && (state_q == IDLE);
  assign effective = accept && (cmd_op != OP_NOP) && (|cmd_mask);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    kill_set_d   = kill_set_q;
    ch_en_d      = ch_en_q;
    kill_pulse_d = 1'b0;
    kill_cnt_d   = kill_cnt_q;
    fire_on      = 1'b0;
    fire_off     = 1'b0;
    fire_kill    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (effective) begin
          unique case (cmd_op)
            OP_ON: begin
              ch_en_d = ch_en_q | cmd_mask;
              fire_on = 1'b1;
            end
            OP_OFF: begin
              ch_en_d  = ch_en_q & ~cmd_mask;
              fire_off = 1'b1;
            end
            OP_KILL: begin
              ch_en_d      = ch_en_q & ~cmd_mask;
              fire_kill    = 1'b1;
              kill_pulse_d = 1'b1;
              kill_set_d   = cmd_mask;
              if (kill_cnt_q != '1) kill_cnt_d = kill_cnt_q + 1'b1;
              // A zero holdoff means "kill and stay killed": no HOLD, no re-arm.
              if (cmd_holdoff != '0) begin
                hold_cnt_d = cmd_holdoff;
                state_d    = HOLD;
              end
            end
            default: ;
          endcase
        end
      end
      HOLD: begin
        hold_cnt_d = hold_cnt_q - 1'b1;
        if (hold_cnt_q == HOLD_W'(1)) begin
          state_d    = IDLE;
          kill_set_d = '0;
          if (AUTO_REARM) begin
            ch_en_d = ch_en_q | kill_set_q;
            fire_on = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      kill_set_q   <= '0;
      ch_en_q      <= '1;
      kill_pulse_q <= 1'b0;
      kill_cnt_q   <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      kill_set_q   <= kill_set_d;
      ch_en_q      <= ch_en_d;
      kill_pulse_q <= kill_pulse_d;
      kill_cnt_q   <= kill_cnt_d;
      // Side effects live in the non-reset branch so a reset edge never issues one.
      if (fire_on)   $asserton(LEVEL, LEVEL);
      if (fire_off)  $assertoff(LEVEL, LEVEL);
      if (fire_kill) $assertkill(LEVEL, LEVEL);
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q == HOLD);
  assign ch_enabled = ch_en_q;
  assign kill_pulse = kill_pulse_q;
  assign kill_cnt   = kill_cnt_q;
  assign ctrl_out   = |ch_en_q;

endmodule

// File: tb/tb_assert_ctrl_seq.sv
// Bench for assert_ctrl_seq: two instances (auto re-arm / 8-bit count, and
// no re-arm / 2-bit count) share stimulus and are checked every cycle.
module tb_assert_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic [3:0] cmd_mask;
  logic [3:0] cmd_holdoff;

  logic       rdy_a, pulse_a, busy_a, ctrl_a;
  logic [3:0] en_a;
  logic [7:0] cnt_a;
  logic       rdy_b, pulse_b, busy_b, ctrl_b;
  logic [3:0] en_b;
  logic [1:0] cnt_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assert_ctrl_seq #(.NUM_CH(4), .LEVEL(1), .HOLD_W(4), .CNT_W(8), .AUTO_REARM(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_mask(cmd_mask), .cmd_holdoff(cmd_holdoff), .cmd_ready(rdy_a),
    .ch_enabled(en_a), .kill_pulse(pulse_a), .busy(busy_a),
    .kill_cnt(cnt_a), .ctrl_out(ctrl_a)
  );

  assert_ctrl_seq #(.NUM_CH(4), .LEVEL(1), .HOLD_W(4), .CNT_W(2), .AUTO_REARM(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_mask(cmd_mask), .cmd_holdoff(cmd_holdoff), .cmd_ready(rdy_b),
    .ch_enabled(en_b), .kill_pulse(pulse_b), .busy(busy_b),
    .kill_cnt(cnt_b), .ctrl_out(ctrl_b)
  );

  // Reference model: enable mask, number of busy cycles still to run, channels
  // owed a re-arm, and an unbounded kill tally clamped at the counter's ceiling.
  typedef struct {
    logic [3:0] en;
    int         busy_left;
    logic [3:0] owed;
    int         kills;
    bit         pulse;
  } model_t;

  model_t m [2];
  int     cnt_max [2] = '{255, 3};
  bit     rearm   [2] = '{1'b1, 1'b0};

  function automatic void model_step(int k, bit rst, bit vld, logic [1:0] op,
                                     logic [3:0] msk, logic [3:0] hold);
    if (!rst) begin
      m[k].en = 4'hF; m[k].busy_left = 0; m[k].owed = 4'h0;
      m[k].kills = 0; m[k].pulse = 1'b0;
      return;
    end
    m[k].pulse = 1'b0;
    if (m[k].busy_left > 0) begin
      m[k].busy_left--;
      if (m[k].busy_left == 0) begin
        if (rearm[k]) m[k].en = m[k].en | m[k].owed;
        m[k].owed = 4'h0;
      end
    end else if (vld && op != 2'b00 && msk != 4'h0) begin
      if (op == 2'b01) m[k].en = m[k].en | msk;
      else             m[k].en = m[k].en & ~msk;
      if (op == 2'b11) begin
        m[k].pulse = 1'b1;
        if (m[k].kills < cnt_max[k]) m[k].kills++;
        m[k].busy_left = int'(hold);
        m[k].owed      = (hold != 0) ? msk : 4'h0;
      end
    end
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++)
      model_step(k, rst_n, cmd_valid, cmd_op, cmd_mask, cmd_holdoff);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, obs, exp);
  endtask

  task automatic check_all();
    check("a.en",    32'(en_a),    32'(m[0].en));
    check("a.ctrl",  32'(ctrl_a),  32'(|m[0].en));
    check("a.ready", 32'(rdy_a),   32'(m[0].busy_left == 0));
    check("a.busy",  32'(busy_a),  32'(m[0].busy_left != 0));
    check("a.pulse", 32'(pulse_a), 32'(m[0].pulse));
    check("a.cnt",   32'(cnt_a),   32'(m[0].kills));
    check("b.en",    32'(en_b),    32'(m[1].en));
    check("b.ctrl",  32'(ctrl_b),  32'(|m[1].en));
    check("b.ready", 32'(rdy_b),   32'(m[1].busy_left == 0));
    check("b.busy",  32'(busy_b),  32'(m[1].busy_left != 0));
    check("b.pulse", 32'(pulse_b), 32'(m[1].pulse));
    check("b.cnt",   32'(cnt_b),   32'(m[1].kills));
  endtask

  // Inputs change only at the falling edge; outputs are compared there too.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input bit vld, input logic [1:0] op, input logic [3:0] msk,
                       input logic [3:0] hold);
    cmd_valid = vld; cmd_op = op; cmd_mask = msk; cmd_holdoff = hold;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 2'b00, 4'h0, 4'h0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 4'h0, 4'h0);
    @(negedge clk);
    tick();
    check("reset.en_a", 32'(en_a), 32'hF);
    check("reset.cnt_a", 32'(cnt_a), 32'h0);
    rst_n = 1'b1;

    // Off commands, back to back.
    drive(1'b1, 2'b10, 4'b0101, 4'h0); tick();
    check("off1.en", 32'(en_a), 32'hA);
    drive(1'b1, 2'b10, 4'b1010, 4'h0); tick();
    check("off2.ctrl", 32'(ctrl_a), 32'h0);
    drive(1'b1, 2'b01, 4'b1111, 4'h0); tick();

    // Kill with holdoff 3, then an on held through HOLD.
    drive(1'b1, 2'b11, 4'b0011, 4'h3); tick();
    check("kill.en", 32'(en_a), 32'hC);
    check("kill.pulse", 32'(pulse_a), 32'h1);
    drive(1'b1, 2'b01, 4'b1111, 4'h0);
    tick(); tick(); tick();
    check("rearm.en", 32'(en_a), 32'hF);
    check("rearm.ready", 32'(rdy_a), 32'h1);
    tick();
    check("held_on.en_b", 32'(en_b), 32'hF);
    idle(1);

    // Zero-holdoff kill, then on right after.
    drive(1'b1, 2'b11, 4'b1000, 4'h0); tick();
    check("kill0.busy", 32'(busy_a), 32'h0);
    idle(3);
    check("kill0.en", 32'(en_a), 32'h7);
    drive(1'b1, 2'b01, 4'b1000, 4'h0); tick();

    // Kill holdoff 5 with no re-arm on dut_b.
    drive(1'b1, 2'b11, 4'b0110, 4'h5); tick();
    idle(6);
    check("norearm.en_b", 32'(en_b), 32'h9);

    // Reset in the second HOLD cycle.
    drive(1'b1, 2'b11, 4'b0001, 4'h5); tick();
    idle(1);
    do_reset();
    check("midhold.busy", 32'(busy_a), 32'h0);

    // Null commands.
    drive(1'b1, 2'b00, 4'b1111, 4'h3); tick();
    drive(1'b1, 2'b11, 4'b0000, 4'h3); tick();
    drive(1'b1, 2'b10, 4'b0000, 4'h0); tick();

    // Saturation on the 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b11, 4'b0001, 4'h0); tick();
    end
    check("sat.cnt_b", 32'(cnt_b), 32'h3);
    idle(1);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom),
            4'($urandom_range(0, 4)));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
